// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI mode 0 responder, MSB first. sclk_in, cs_bar and
// mosi are oversampled in the clk domain, so clk must run at least 4x sclk.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | deselected; miso held 0, sclk edges ignored
// ST_ACTIVE | selected; words shift on sclk edges until cs_bar rises
module spi_slave_responder #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk_in,
    input  logic              cs_bar,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_rise;
    logic                   cs_fall;

    logic                   start_word;
    logic                   shift_out;
    logic                   shift_in;
    logic                   abort_word;

    logic [CNT_W-1:0]       bit_cnt;
    logic                   last_bit;
    // MSB of the outgoing word lives in miso, so the shifter holds only the rest
    logic [DATA_W-2:0]      tx_sh;
    logic [DATA_W-2:0]      rx_sh;
    logic [DATA_W-1:0]      rx_word;

    logic [DATA_W-1:0]      tx_buf;
    logic                   tx_full;
    logic                   consume;
    logic                   load_ok;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
    assign rx_word   = {rx_sh, mosi_s};

    assign consume   = start_word & tx_full;
    // a load in the same cycle the buffer is consumed refills it straight away
    assign load_ok   = tx_load & (~tx_full | consume);

    assign tx_ready  = ~tx_full;
    assign busy      = (state_q == ST_ACTIVE);

    // Pin synchronisers plus one edge-detect stage. The cs chain resets low so a
    // cs_bar already low at reset release cannot look like a falling edge: a
    // real high must pass through before the next select is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_bar};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle shift strobes; a cs rise masks any sclk edge.
    always_comb begin
        state_d    = state_q;
        start_word = 1'b0;
        shift_out  = 1'b0;
        shift_in   = 1'b0;
        abort_word = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_ACTIVE;
                    start_word = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d    = ST_IDLE;
                    abort_word = 1'b1;
                end else begin
                    if (sclk_rise) begin
                        shift_in = 1'b1;
                    end
                    if (sclk_fall) begin
                        if (bit_cnt == '0) begin
                            start_word = 1'b1;
                        end else begin
                            shift_out = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shift registers, bit counter, miso and received-word handoff.
    always_ff @(posedge clk) begin
        if (reset) begin
            miso     <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (start_word) begin
                miso    <= tx_full ? tx_buf[DATA_W-1] : 1'b0;
                tx_sh   <= tx_full ? tx_buf[DATA_W-2:0] : '0;
                bit_cnt <= '0;
            end else if (shift_out) begin
                miso  <= tx_sh[DATA_W-2];
                tx_sh <= tx_sh << 1;
            end else if (shift_in) begin
                rx_sh <= rx_word[DATA_W-2:0];
                if (last_bit) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (abort_word) begin
                miso    <= 1'b0;
                bit_cnt <= '0;
                rx_sh   <= '0;
            end
        end
    end

    // One-word TX buffer and the sticky underrun flag (set beats clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if (load_ok) begin
                tx_buf <= tx_data;
            end
            if (load_ok) begin
                tx_full <= 1'b1;
            end else if (consume) begin
                tx_full <= 1'b0;
            end
            if (start_word && !tx_full) begin
                tx_underrun <= 1'b1;
            end else if (load_ok) begin
                tx_underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a behavioural SPI mode 0 master, a received-word
// scoreboard popped on rx_valid, and one task per scenario.
module tb_spi_slave_responder;

    logic       clk;
    logic       reset;
    logic       sclk_in;
    logic       cs_bar;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    int         checks = 0;
    int         errors = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_v;
    logic       rx_valid_prev = 1'b0;

    logic [7:0] mo_w [4];
    logic [7:0] mi_w [4];

    spi_slave_responder #(
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sclk_in     (sclk_in),
        .cs_bar      (cs_bar),
        .mosi        (mosi),
        .miso        (miso),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // received-word scoreboard and rx_valid pulse-width check
    always @(negedge clk) begin
        if (!reset && rx_valid) begin
            checks++;
            if (exp_rx.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected got %h expected no word", rx_data);
            end else begin
                exp_v = exp_rx.pop_front();
                if (rx_data !== exp_v) begin
                    errors++;
                    $display("FAIL rx_data got %h expected %h", rx_data, exp_v);
                end
            end
            checks++;
            if (rx_valid_prev !== 1'b0) begin
                errors++;
                $display("FAIL rx_valid_width got multi-cycle pulse expected one cycle");
            end
        end
        rx_valid_prev = rx_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tx_push(input logic [7:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // Master: n_words words from mo_w, last one cut to last_bits bits.
    // A full frame raises cs_bar while sclk is still high, so the trailing
    // sclk fall lands in IDLE and does not pull the next buffered word.
    task automatic spi_frame(input int n_words, input int last_bits);
        cs_bar = 1'b0;
        #80;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_active got %b expected 1", busy);
        end
        for (int w = 0; w < n_words; w++) begin
            int nb;
            nb = (w == n_words - 1) ? last_bits : 8;
            mi_w[w] = 8'h00;
            if (nb == 8) exp_rx.push_back(mo_w[w]);
            for (int i = 0; i < nb; i++) begin
                sclk_in = 1'b0;
                mosi    = mo_w[w][7-i];
                #40;
                mi_w[w][7-i] = miso;
                sclk_in = 1'b1;
                #40;
            end
        end
        if (last_bits == 8) begin
            cs_bar  = 1'b1;
            #40;
            sclk_in = 1'b0;
        end else begin
            sclk_in = 1'b0;
            #40;
            cs_bar  = 1'b1;
        end
        #80;
        checks++;
        if (exp_rx.size() != 0) begin
            errors++;
            $display("FAIL rx_missing got %0d words pending expected 0", exp_rx.size());
            exp_rx.delete();
        end
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        sclk_in = 1'b0;
        cs_bar  = 1'b1;
        mosi    = 1'b0;
        tx_data = 8'h00;
        tx_load = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({miso, tx_ready, rx_data, rx_valid, tx_underrun, busy} !== 13'b0_1_00000000_0_0_0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected %b",
                     {miso, tx_ready, rx_data, rx_valid, tx_underrun, busy}, 13'b0_1_00000000_0_0_0);
        end
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if ({busy, tx_ready, miso} !== 3'b010) begin
            errors++;
            $display("FAIL reset_release got %b expected 010", {busy, tx_ready, miso});
        end
    endtask

    task automatic test_basic;
        tx_push(8'hA5);
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_loaded got %b expected 0", tx_ready);
        end
        mo_w[0] = 8'h3C;
        spi_frame(1, 8);
        checks++;
        if (mi_w[0] !== 8'hA5) begin
            errors++;
            $display("FAIL basic_miso got %h expected a5", mi_w[0]);
        end
        checks++;
        if (rx_data !== 8'h3C) begin
            errors++;
            $display("FAIL basic_rx_hold got %h expected 3c", rx_data);
        end
        checks++;
        if ({tx_ready, tx_underrun, busy, miso} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_idle got %b expected 1000", {tx_ready, tx_underrun, busy, miso});
        end
    endtask

    task automatic test_back_to_back;
        bit got_ready;
        got_ready = 1'b0;
        tx_push(8'h55);
        mo_w[0] = 8'h11;
        mo_w[1] = 8'h22;
        fork
            spi_frame(2, 8);
            begin
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (tx_ready === 1'b1) begin
                        got_ready = 1'b1;
                        break;
                    end
                end
                if (got_ready) tx_push(8'h66);
            end
        join
        checks++;
        if (!got_ready) begin
            errors++;
            $display("FAIL b2b_ready_timeout got tx_ready 0 expected 1 within 100 cycles");
        end
        checks++;
        if (mi_w[0] !== 8'h55 || mi_w[1] !== 8'h66) begin
            errors++;
            $display("FAIL b2b_miso got %h %h expected 55 66", mi_w[0], mi_w[1]);
        end
        checks++;
        if ({tx_ready, tx_underrun} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_flags got %b expected 10", {tx_ready, tx_underrun});
        end
    endtask

    task automatic test_underrun;
        checks++;
        if ({tx_ready, tx_underrun} !== 2'b10) begin
            errors++;
            $display("FAIL underrun_pre got %b expected 10", {tx_ready, tx_underrun});
        end
        mo_w[0] = 8'hFF;
        spi_frame(1, 8);
        checks++;
        if (mi_w[0] !== 8'h00) begin
            errors++;
            $display("FAIL underrun_miso got %h expected 00", mi_w[0]);
        end
        checks++;
        if (tx_underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_set got %b expected 1", tx_underrun);
        end
        tx_push(8'h77);
        checks++;
        if ({tx_underrun, tx_ready} !== 2'b00) begin
            errors++;
            $display("FAIL underrun_clear got %b expected 00", {tx_underrun, tx_ready});
        end
    endtask

    task automatic test_abort;
        mo_w[0] = 8'hB0;
        spi_frame(1, 5);
        checks++;
        if (mi_w[0][7:3] !== 5'b01110) begin
            errors++;
            $display("FAIL abort_miso got %b expected 01110", mi_w[0][7:3]);
        end
        checks++;
        if (rx_data !== 8'hFF) begin
            errors++;
            $display("FAIL abort_rx_hold got %h expected ff", rx_data);
        end
        checks++;
        if ({tx_ready, busy, miso} !== 3'b100) begin
            errors++;
            $display("FAIL abort_idle got %b expected 100", {tx_ready, busy, miso});
        end
        tx_push(8'h9A);
        mo_w[0] = 8'h5B;
        spi_frame(1, 8);
        checks++;
        if (mi_w[0] !== 8'h9A || rx_data !== 8'h5B) begin
            errors++;
            $display("FAIL abort_recover got miso %h rx %h expected 9a 5b", mi_w[0], rx_data);
        end
    endtask

    task automatic test_reset_midword;
        logic [7:0] pat;
        pat = 8'hE6;
        tx_push(8'hC3);
        cs_bar = 1'b0;
        #80;
        for (int i = 0; i < 3; i++) begin
            sclk_in = 1'b0;
            mosi    = pat[7-i];
            #40;
            sclk_in = 1'b1;
            #40;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({miso, tx_ready, rx_data, rx_valid, tx_underrun, busy} !== 13'b0_1_00000000_0_0_0) begin
            errors++;
            $display("FAIL midreset_outputs got %b expected %b",
                     {miso, tx_ready, rx_data, rx_valid, tx_underrun, busy}, 13'b0_1_00000000_0_0_0);
        end
        reset = 1'b0;
        for (int i = 3; i < 8; i++) begin
            sclk_in = 1'b0;
            mosi    = pat[7-i];
            #40;
            sclk_in = 1'b1;
            #40;
        end
        checks++;
        if ({busy, rx_data} !== 9'b0_00000000) begin
            errors++;
            $display("FAIL midreset_ignored got busy %b rx %h expected 0 00", busy, rx_data);
        end
        sclk_in = 1'b0;
        #40;
        cs_bar = 1'b1;
        #80;
        tx_push(8'h3E);
        mo_w[0] = 8'hD2;
        spi_frame(1, 8);
        checks++;
        if (mi_w[0] !== 8'h3E || rx_data !== 8'hD2) begin
            errors++;
            $display("FAIL midreset_recover got miso %h rx %h expected 3e d2", mi_w[0], rx_data);
        end
    endtask

    task automatic test_load_ignored;
        tx_push(8'hB4);
        tx_push(8'h4B);
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL ignored_ready got %b expected 0", tx_ready);
        end
        mo_w[0] = 8'h01;
        spi_frame(1, 8);
        checks++;
        if (mi_w[0] !== 8'hB4) begin
            errors++;
            $display("FAIL ignored_miso got %h expected b4", mi_w[0]);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignored_drained got %b expected 1", tx_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_midword();
        test_load_ignored();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
